// File: rtl/apb_lsu_master_if.sv
// +-----------------------------------------------------------------------+
// | apb_lsu_master_if : request/response and APB4 signals of the LSU      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface apb_lsu_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_misaligned;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  // LSU side: accepts requests, returns responses, initiates APB transfers
  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_misaligned,
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  // Environment side: pipeline plus data-memory APB slave
  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_misaligned,
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/apb_lsu_master.sv
// +-----------------------------------------------------------------------+
// | apb_lsu_master : turns one load/store request into one APB4 transfer  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module apb_lsu_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  apb_lsu_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_MISAL  = 2'd3
  } state_t;

  localparam int              CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              C_TO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_lane;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_req_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [31:0]       r_pwdata;
  logic [3:0]        r_pstrb;

  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_mis;

  logic              w_accept;
  logic              w_misal;
  logic              w_done;
  logic              w_abort;
  logic [31:0]       w_pwdata;
  logic [3:0]        w_pstrb;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  assign w_accept = r_req_ready && bus.req_valid;
  assign w_done   = (r_state == S_ACCESS) && bus.pready;
  assign w_abort  = C_TO_EN && (r_state == S_ACCESS) && !bus.pready && (r_cnt == C_TO_LAST);

  always_comb begin
    w_misal = 1'b0;
    case (bus.req_size)
      2'd0:    w_misal = 1'b0;
      2'd1:    w_misal = bus.req_addr[0];
      2'd2:    w_misal = (bus.req_addr[1:0] != 2'b00);
      default: w_misal = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_misal ? S_MISAL : S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_state_nxt = S_IDLE;
      S_MISAL:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Store data is replicated across lanes so the strobe alone picks the bytes
  always_comb begin
    w_pwdata = '0;
    w_pstrb  = '0;
    if (bus.req_we) begin
      case (bus.req_size)
        2'd0: begin
          w_pwdata = {4{bus.req_wdata[7:0]}};
          w_pstrb  = 4'b0001 << bus.req_addr[1:0];
        end
        2'd1: begin
          w_pwdata = {2{bus.req_wdata[15:0]}};
          w_pstrb  = 4'b0011 << bus.req_addr[1:0];
        end
        default: begin
          w_pwdata = bus.req_wdata;
          w_pstrb  = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = bus.prdata[7:0];
    case (r_lane)
      2'd0:    w_byte = bus.prdata[7:0];
      2'd1:    w_byte = bus.prdata[15:8];
      2'd2:    w_byte = bus.prdata[23:16];
      default: w_byte = bus.prdata[31:24];
    endcase
    w_half = r_lane[1] ? bus.prdata[31:16] : bus.prdata[15:0];
    case (r_size)
      2'd0:    w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = bus.prdata;
    endcase
    if (r_we) w_load = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_mis   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= 1'b0;

      if (w_accept) begin
        r_we   <= bus.req_we;
        r_size <= bus.req_size;
        r_uns  <= bus.req_unsigned;
        r_lane <= bus.req_addr[1:0];
        if (w_misal) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_mis   <= 1'b1;
          r_rsp_rdata <= '0;
        end else begin
          r_psel   <= 1'b1;
          r_paddr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          r_pwrite <= bus.req_we;
          r_pwdata <= w_pwdata;
          r_pstrb  <= w_pstrb;
        end
      end

      if (r_state == S_SETUP) r_penable <= 1'b1;

      if (r_state == S_ACCESS) begin
        if (w_done) begin
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_cnt       <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= bus.pslverr;
          r_rsp_mis   <= 1'b0;
          r_rsp_rdata <= bus.pslverr ? 32'd0 : w_load;
        end else if (w_abort) begin
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_cnt       <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_mis   <= 1'b0;
          r_rsp_rdata <= '0;
        end else if (C_TO_EN) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.psel           = r_psel;
  assign bus.penable        = r_penable;
  assign bus.pwrite         = r_pwrite;
  assign bus.paddr          = r_paddr;
  assign bus.pwdata         = r_pwdata;
  assign bus.pstrb          = r_pstrb;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.rsp_err        = r_rsp_err;
  assign bus.rsp_misaligned = r_rsp_mis;

endmodule

`default_nettype wire

// File: tb/tb_apb_lsu_master.sv
// +-----------------------------------------------------------------------+
// | tb_apb_lsu_master : directed bench with a small APB memory slave      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_apb_lsu_master;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_lsu_master_if #(.ADDR_W(ADDR_W)) bus ();

  apb_lsu_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  int   cfg_wait      = 0;
  logic cfg_err       = 1'b0;
  logic cfg_setup_rdy = 1'b0;
  logic [31:0] mem [16];

  int          o_lat;
  logic [31:0] o_rdata, o_paddr, o_pwdata;
  logic [3:0]  o_pstrb;
  logic        o_pwrite, o_err, o_mis, o_psel_seen, o_setup_seen, o_stable;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // APB slave: cfg_wait low cycles in ACCESS, then pready with cfg_err
  initial begin
    int wcnt;
    int idx;
    wcnt        = 0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'hdead_beef;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      idx = int'(bus.paddr[5:2]);
      if (bus.psel && bus.penable) begin
        if (wcnt >= cfg_wait) begin
          bus.pready  = 1'b1;
          bus.pslverr = cfg_err;
          bus.prdata  = mem[idx];
          if (bus.pwrite && !cfg_err)
            for (int b = 0; b < 4; b++)
              if (bus.pstrb[b]) mem[idx][8*b +: 8] = bus.pwdata[8*b +: 8];
        end else begin
          bus.pready = 1'b0;
          wcnt++;
        end
      end else begin
        wcnt        = 0;
        bus.pready  = bus.psel && cfg_setup_rdy;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'hdead_beef;
      end
    end
  end

  // Offer one request, then watch the bus until the response strobe
  task automatic run(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) check1("req_ready_wait", bus.req_ready, 1'b1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    o_lat = 0; o_rdata = 'x; o_err = 1'bx; o_mis = 1'bx;
    o_psel_seen = 1'b0; o_setup_seen = 1'b0; o_stable = 1'b1;
    o_paddr = 'x; o_pwdata = 'x; o_pstrb = 'x; o_pwrite = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      if (bus.rsp_valid) begin
        o_lat   = c;
        o_rdata = bus.rsp_rdata;
        o_err   = bus.rsp_err;
        o_mis   = bus.rsp_misaligned;
        break;
      end
      if (bus.psel) o_psel_seen = 1'b1;
      if (bus.psel && !bus.penable && !o_setup_seen) begin
        o_setup_seen = 1'b1;
        o_paddr  = bus.paddr;
        o_pwdata = bus.pwdata;
        o_pstrb  = bus.pstrb;
        o_pwrite = bus.pwrite;
      end else if (o_setup_seen) begin
        if (!bus.psel || !bus.penable || bus.paddr !== o_paddr || bus.pwdata !== o_pwdata ||
            bus.pstrb !== o_pstrb || bus.pwrite !== o_pwrite)
          o_stable = 1'b0;
      end
      @(negedge clk);
    end
    if (o_lat == 0) check1("rsp_timeout", bus.rsp_valid, 1'b1);
  endtask

  initial begin
    int seen;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check1("rst_req_ready", bus.req_ready, 1'b0);
    check1("rst_psel", bus.psel, 1'b0);
    check1("rst_penable", bus.penable, 1'b0);
    check1("rst_pwrite", bus.pwrite, 1'b0);
    check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check1("rst_rsp_err", bus.rsp_err, 1'b0);
    check1("rst_rsp_mis", bus.rsp_misaligned, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_pstrb", 32'(bus.pstrb), 32'h0);
    rst = 1'b0;

    run(1'b1, 2'd2, 1'b0, 32'd24, 32'haaaa_aaaa);
    check("sw_paddr", o_paddr, 32'd24);
    check("sw_pstrb", 32'(o_pstrb), 32'hf);
    check("sw_pwdata", o_pwdata, 32'haaaa_aaaa);
    check1("sw_pwrite", o_pwrite, 1'b1);
    check1("sw_err", o_err, 1'b0);
    check("sw_rdata", o_rdata, 32'h0);
    check("sw_lat", 32'(o_lat), 32'd3);
    @(negedge clk);
    check1("sw_rsp_pulse", bus.rsp_valid, 1'b0);

    run(1'b0, 2'd2, 1'b0, 32'd24, 32'h0);
    check("lw_rdata", o_rdata, 32'haaaa_aaaa);
    check("lw_lat", 32'(o_lat), 32'd3);
    check("lw_pstrb", 32'(o_pstrb), 32'h0);
    check("lw_pwdata", o_pwdata, 32'h0);
    check1("lw_pwrite", o_pwrite, 1'b0);
    @(negedge clk);
    check("lw_rdata_hold", bus.rsp_rdata, 32'haaaa_aaaa);

    run(1'b0, 2'd1, 1'b0, 32'd24, 32'h0);
    check("lh24", o_rdata, 32'hffff_aaaa);
    run(1'b0, 2'd0, 1'b0, 32'd24, 32'h0);
    check("lb24", o_rdata, 32'hffff_ffaa);
    run(1'b0, 2'd1, 1'b1, 32'd24, 32'h0);
    check("lhu24", o_rdata, 32'h0000_aaaa);
    run(1'b0, 2'd0, 1'b1, 32'd24, 32'h0);
    check("lbu24", o_rdata, 32'h0000_00aa);
    run(1'b0, 2'd0, 1'b0, 32'd27, 32'h0);
    check("lb27", o_rdata, 32'hffff_ffaa);

    run(1'b1, 2'd2, 1'b0, 32'd24, 32'h1234_5678);
    run(1'b0, 2'd0, 1'b1, 32'd25, 32'h0);
    check("lbu25", o_rdata, 32'h0000_0056);
    run(1'b0, 2'd1, 1'b0, 32'd26, 32'h0);
    check("lh26", o_rdata, 32'h0000_1234);
    run(1'b0, 2'd0, 1'b0, 32'd24, 32'h0);
    check("lb24_pos", o_rdata, 32'h0000_0078);

    run(1'b1, 2'd0, 1'b0, 32'd16, 32'h0001_0368);
    check("sb16_paddr", o_paddr, 32'd16);
    check("sb16_pstrb", 32'(o_pstrb), 32'h1);
    check("sb16_pwdata", o_pwdata, 32'h6868_6868);
    run(1'b1, 2'd1, 1'b0, 32'd14, 32'h0001_0368);
    check("sh14_paddr", o_paddr, 32'd12);
    check("sh14_pstrb", 32'(o_pstrb), 32'hc);
    check("sh14_pwdata", o_pwdata, 32'h0368_0368);
    run(1'b1, 2'd0, 1'b0, 32'd19, 32'h0001_0368);
    check("sb19_paddr", o_paddr, 32'd16);
    check("sb19_pstrb", 32'(o_pstrb), 32'h8);
    run(1'b0, 2'd2, 1'b0, 32'd16, 32'h0);
    check("lw16_merged", o_rdata, 32'h6800_0068);
    run(1'b0, 2'd2, 1'b0, 32'd12, 32'h0);
    check("lw12_merged", o_rdata, 32'h0368_0000);

    run(1'b1, 2'd2, 1'b0, 32'h0000_1001, 32'h1111_1111);
    check1("mis_sw_psel", o_psel_seen, 1'b0);
    check("mis_sw_lat", 32'(o_lat), 32'd1);
    check1("mis_sw_err", o_err, 1'b1);
    check1("mis_sw_mis", o_mis, 1'b1);
    @(negedge clk);
    check1("mis_rsp_pulse", bus.rsp_valid, 1'b0);
    run(1'b0, 2'd1, 1'b0, 32'd3, 32'h0);
    check1("mis_lh_psel", o_psel_seen, 1'b0);
    check("mis_lh_lat", 32'(o_lat), 32'd1);
    check1("mis_lh_err", o_err, 1'b1);
    check1("mis_lh_mis", o_mis, 1'b1);
    run(1'b0, 2'd3, 1'b0, 32'd0, 32'h0);
    check1("mis_sz3_psel", o_psel_seen, 1'b0);
    check1("mis_sz3_mis", o_mis, 1'b1);
    run(1'b0, 2'd2, 1'b0, 32'hffff_fffc, 32'h0);
    check("top_paddr", o_paddr, 32'hffff_fffc);
    check1("top_mis_clear", o_mis, 1'b0);
    check1("top_err", o_err, 1'b0);

    cfg_wait = 5; cfg_setup_rdy = 1'b1;
    run(1'b0, 2'd2, 1'b0, 32'd24, 32'h0);
    check("wait5_lat", 32'(o_lat), 32'd8);
    check1("wait5_stable", o_stable, 1'b1);
    check("wait5_rdata", o_rdata, 32'h1234_5678);
    cfg_wait = 0; cfg_setup_rdy = 1'b0;

    cfg_err = 1'b1;
    run(1'b0, 2'd2, 1'b0, 32'd24, 32'h0);
    check1("slverr_err", o_err, 1'b1);
    check("slverr_rdata", o_rdata, 32'h0);
    check1("slverr_mis", o_mis, 1'b0);
    check("slverr_lat", 32'(o_lat), 32'd3);
    cfg_err = 1'b0;

    cfg_wait = 1000;
    run(1'b0, 2'd2, 1'b0, 32'd24, 32'h0);
    check("timeout_lat", 32'(o_lat), 32'd18);
    check1("timeout_err", o_err, 1'b1);
    check("timeout_rdata", o_rdata, 32'h0);
    cfg_wait = 5;

    // Reset pulse while the slave is still inserting wait states
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd24;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check1("pre_rst_penable", bus.penable, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check1("mid_rst_psel", bus.psel, 1'b0);
    check1("mid_rst_penable", bus.penable, 1'b0);
    check1("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", 32'(seen), 32'd0);
    check1("post_rst_ready", bus.req_ready, 1'b1);
    cfg_wait = 0;
    run(1'b0, 2'd2, 1'b0, 32'd24, 32'h0);
    check("post_rst_rdata", o_rdata, 32'h1234_5678);
    check("post_rst_lat", 32'(o_lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
